imem_loader: RTL and testbench
==============================

# imem_loader

Boot-time instruction-memory writer for the `chocorrol` single-cycle MIPS core. It accepts a framed byte stream on a valid/ready handshake and assembles big-endian 32-bit instruction words. It writes those words to the instruction memory's write port and holds the core in reset until the whole program is loaded and its checksum verifies. It is the producer side of the core's instruction-fetch interface: the core only reads instruction memory, and this block fills it.

## Interface
Parameters:
- `BASE_ADDR`, default 32'h0000_0000: byte address written by the first word. Must be a multiple of 4.
- `ADDR_W`, default 32: width of `wrAddrOut`.

Ports:
- `clkIn`  in  1  system clock; every register updates on the rising edge.
- `rstIn`  in  1  reset, synchronous and active-high.
- `byteIn`  in  8  stream byte.
- `byteValidIn`  in  1  `byteIn` is valid.
- `byteReadyOut`  out  1  the block can accept a byte this cycle.
- `wrEnOut`  out  1  instruction-memory write strobe, one cycle per word.
- `wrAddrOut`  out  ADDR_W  byte address of the word being written.
- `wrDataOut`  out  32  instruction word being written.
- `cpuResetOut`  out  1  holds the core in reset while high.
- `loadDoneOut`  out  1  program loaded and checksum matched.
- `errOut`  out  1  checksum mismatch; sticky until `rstIn`.

## Operation
- Frame format, in order:
  - COUNT byte N (0–255): number of words.
  - 4·N data bytes, most significant byte first; the first byte of each word goes to [31:24].
  - One CHECK byte: XOR of all 4·N data bytes. COUNT and CHECK are excluded from the XOR.
- A byte is accepted on any rising edge where `byteValidIn && byteReadyOut` is true.
- State machine:
  - COUNT: latch N, clear the word index k, the byte index (0–3) and the checksum accumulator. Go to DATA if N≠0, otherwise to CHECK.
  - DATA: shift each accepted byte into the word register and XOR it into the accumulator.
    - On the 4th byte of a word, issue a write, increment k and reset the byte index.
    - After word N−1 is complete, go to CHECK.
  - CHECK: on the accepted byte, go to DONE if it equals the accumulator, otherwise go to ERROR.
  - DONE: terminal until reset. `loadDoneOut`=1, `cpuResetOut`=0.
  - ERROR: terminal until reset. `errOut`=1, `cpuResetOut`=1.
- `byteReadyOut` = 1 in COUNT, DATA and CHECK, and 0 in DONE and ERROR. Bytes offered in DONE or ERROR are not consumed and have no effect.
- Write address = `BASE_ADDR + 4·k`, truncated to `ADDR_W` bits, with k = 0..N−1. Wrap-around past 2^ADDR_W is not detected.
- N=0: no writes are issued; the expected CHECK byte is 8'h00.

## Timing
- Reset values, applied on the first rising edge with `rstIn`=1:
  - state = COUNT.
  - `byteReadyOut`=1, `wrEnOut`=0, `wrAddrOut`=0, `wrDataOut`=0.
  - `cpuResetOut`=1, `loadDoneOut`=0, `errOut`=0.
  - All counters and the accumulator = 0.
- `rstIn` takes priority over any handshake in the same cycle; that byte is dropped.
- Write latency: `wrEnOut` is high for exactly the one cycle after the edge that accepts a word's 4th byte. `wrAddrOut` and `wrDataOut` are valid during that cycle and hold their values afterwards.
- Back-to-back bytes are accepted at one per cycle. Consecutive words therefore produce `wrEnOut` pulses spaced by at least 4 cycles.
- If the last data byte is accepted on edge E:
  - The word write is visible in cycle E+1.
  - The CHECK byte can be accepted at E+1 at the earliest.
- `cpuResetOut` falls, and `loadDoneOut` rises, on the same edge that moves the state to DONE: the edge after the matching CHECK byte is accepted. The core's first fetch therefore happens after the last write has completed.
- Reset mid-load discards the partial word and the count; words already written stay in memory. The next accepted byte is treated as COUNT.
- Bubbles (`byteValidIn`=0) can occur anywhere in the frame; all state holds through them.

## Test plan
- Reset, then N=1, bytes 20,08,00,05, CHECK 8'h2D:
  - one `wrEnOut` pulse with addr 0x0 and data 32'h2008_0005;
  - `cpuResetOut` falls one cycle after CHECK is accepted; `loadDoneOut`=1.
- `BASE_ADDR`=0x100, N=3, streamed back-to-back with no bubbles:
  - writes at 0x100, 0x104 and 0x108, each spaced 4 cycles apart;
  - correct XOR leads to DONE.
- N=2 with CHECK off by one bit:
  - two writes occur;
  - `errOut`=1, `cpuResetOut` stays 1, `byteReadyOut`=0;
  - further bytes are ignored.
- N=0, CHECK 8'h00:
  - no `wrEnOut`; DONE two edges after COUNT is accepted.
  - With CHECK 8'h01: ERROR.
- Assert `rstIn` after 2 bytes of word 1 in an N=4 load, then send a fresh N=1 frame:
  - the write goes to 0x0 with the new data;
  - all outputs return to their reset values for the reset cycle.
- Random `byteValidIn` bubbles during an N=5 load:
  - written data and addresses are identical to the bubble-free run;
  - no bytes are duplicated.

Source files
------------

// File: rtl/imem_loader.sv
// Boot loader: assembles a framed byte stream into big-endian 32-bit words and writes them to instruction memory.
// Latency: write strobe one cycle after a word's 4th byte; DONE/ERROR visible the cycle after the CHECK byte.
// Backpressure: byteReadyOut high in COUNT/DATA/CHECK (one byte per cycle), low in DONE/ERROR (stream stalls).
//
// Ports:
//   clkIn, rstIn                   clock, synchronous active-high reset
//   byteIn/byteValidIn/byteReadyOut framed input stream (COUNT, 4*N data bytes, CHECK)
//   wrEnOut/wrAddrOut/wrDataOut    instruction-memory write port
//   cpuResetOut                    holds the core in reset until the program verifies
//   loadDoneOut, errOut            load complete / checksum mismatch (both terminal until reset)
module imem_loader #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          ADDR_W    = 32
) (
    input  logic              clkIn,
    input  logic              rstIn,
    input  logic [7:0]        byteIn,
    input  logic              byteValidIn,
    output logic              byteReadyOut,
    output logic              wrEnOut,
    output logic [ADDR_W-1:0] wrAddrOut,
    output logic [31:0]       wrDataOut,
    output logic              cpuResetOut,
    output logic              loadDoneOut,
    output logic              errOut
);

    typedef enum logic [2:0] {
        S_COUNT = 3'd0,
        S_DATA  = 3'd1,
        S_CHECK = 3'd2,
        S_DONE  = 3'd3,
        S_ERROR = 3'd4
    } state_t;

    localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

    state_t            state, stateNext;
    logic [7:0]        wordCnt, wordCntNext;
    logic [7:0]        wordIdx, wordIdxNext;
    logic [1:0]        byteIdx, byteIdxNext;
    logic [7:0]        acc, accNext;
    // First three bytes of the word in flight, oldest in [23:16].
    logic [23:0]       shiftReg, shiftRegNext;
    logic              wrEn, wrEnNext;
    logic [ADDR_W-1:0] wrAddr, wrAddrNext;
    logic [31:0]       wrData, wrDataNext;
    logic              accept;

    assign accept = byteValidIn && byteReadyOut;

    always_ff @(posedge clkIn) begin
        if (rstIn) begin
            state    <= S_COUNT;
            wordCnt  <= 8'd0;
            wordIdx  <= 8'd0;
            byteIdx  <= 2'd0;
            acc      <= 8'd0;
            shiftReg <= 24'd0;
            wrEn     <= 1'b0;
            wrAddr   <= '0;
            wrData   <= 32'd0;
        end else begin
            state    <= stateNext;
            wordCnt  <= wordCntNext;
            wordIdx  <= wordIdxNext;
            byteIdx  <= byteIdxNext;
            acc      <= accNext;
            shiftReg <= shiftRegNext;
            wrEn     <= wrEnNext;
            wrAddr   <= wrAddrNext;
            wrData   <= wrDataNext;
        end
    end

    always_comb begin
        stateNext    = state;
        wordCntNext  = wordCnt;
        wordIdxNext  = wordIdx;
        byteIdxNext  = byteIdx;
        accNext      = acc;
        shiftRegNext = shiftReg;
        wrEnNext     = 1'b0;
        wrAddrNext   = wrAddr;
        wrDataNext   = wrData;

        case (state)
            S_COUNT: begin
                if (accept) begin
                    wordCntNext = byteIn;
                    wordIdxNext = 8'd0;
                    byteIdxNext = 2'd0;
                    accNext     = 8'd0;
                    // An empty program still needs its (zero) CHECK byte.
                    stateNext   = (byteIn != 8'd0) ? S_DATA : S_CHECK;
                end
            end
            S_DATA: begin
                if (accept) begin
                    accNext = acc ^ byteIn;
                    if (byteIdx == 2'd3) begin
                        wrEnNext    = 1'b1;
                        wrDataNext  = {shiftReg, byteIn};
                        // Address wraps silently at 2^ADDR_W.
                        wrAddrNext  = BASE + ADDR_W'({wordIdx, 2'b00});
                        wordIdxNext = wordIdx + 8'd1;
                        byteIdxNext = 2'd0;
                        if (wordIdx == wordCnt - 8'd1) begin
                            stateNext = S_CHECK;
                        end
                    end else begin
                        shiftRegNext = {shiftReg[15:0], byteIn};
                        byteIdxNext  = byteIdx + 2'd1;
                    end
                end
            end
            S_CHECK: begin
                if (accept) begin
                    stateNext = (byteIn == acc) ? S_DONE : S_ERROR;
                end
            end
            S_DONE:  stateNext = S_DONE;
            S_ERROR: stateNext = S_ERROR;
            default: stateNext = S_COUNT;
        endcase
    end

    // Status outputs decode the registered state, so they change on the
    // same edge that enters DONE/ERROR.
    assign byteReadyOut = (state == S_COUNT) || (state == S_DATA) || (state == S_CHECK);
    assign cpuResetOut  = (state != S_DONE);
    assign loadDoneOut  = (state == S_DONE);
    assign errOut       = (state == S_ERROR);
    assign wrEnOut      = wrEn;
    assign wrAddrOut    = wrAddr;
    assign wrDataOut    = wrData;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: two instances (base 0x0 and 0x100) fed the same stream.
// Writes are logged on the falling edge and compared against hand-computed words/addresses.
// Status outputs are sampled 1 time unit after the rising edge.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  byteDat = 8'd0;
    logic        byteVld = 1'b0;

    logic        byteRdy, wrEn, cpuRst, loadDone, err;
    logic [31:0] wrAddr, wrData;
    logic        byteRdy1, wrEn1, cpuRst1, loadDone1, err1;
    logic [31:0] wrAddr1, wrData1;

    int totalCnt = 0;
    int badCnt   = 0;
    int cyc      = 0;

    logic [31:0] logAddr[$];
    logic [31:0] logData[$];
    int          logCyc[$];
    logic [31:0] logAddr1[$];

    imem_loader #(.BASE_ADDR(32'h0000_0000), .ADDR_W(32)) dut0 (
        .clkIn(clk), .rstIn(rst), .byteIn(byteDat), .byteValidIn(byteVld),
        .byteReadyOut(byteRdy), .wrEnOut(wrEn), .wrAddrOut(wrAddr), .wrDataOut(wrData),
        .cpuResetOut(cpuRst), .loadDoneOut(loadDone), .errOut(err)
    );

    imem_loader #(.BASE_ADDR(32'h0000_0100), .ADDR_W(32)) dut1 (
        .clkIn(clk), .rstIn(rst), .byteIn(byteDat), .byteValidIn(byteVld),
        .byteReadyOut(byteRdy1), .wrEnOut(wrEn1), .wrAddrOut(wrAddr1), .wrDataOut(wrData1),
        .cpuResetOut(cpuRst1), .loadDoneOut(loadDone1), .errOut(err1)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (wrEn) begin
            logAddr.push_back(wrAddr);
            logData.push_back(wrData);
            logCyc.push_back(cyc);
        end
        if (wrEn1) logAddr1.push_back(wrAddr1);
    end

    task automatic checkEq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        totalCnt++;
        if (got !== exp) begin
            badCnt++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clearLog();
        logAddr.delete();
        logData.delete();
        logCyc.delete();
        logAddr1.delete();
    endtask

    // Returns 1 time unit after the edge that accepted the byte.
    task automatic sendByte(input logic [7:0] b);
        int guard;
        guard   = 0;
        byteDat = b;
        byteVld = 1'b1;
        forever begin
            @(negedge clk);
            if (byteRdy) break;
            guard++;
            if (guard > 50) begin
                checkEq("acceptTimeout", 64'd0, 64'd1);
                byteVld = 1'b0;
                return;
            end
        end
        @(posedge clk);
        #1;
        byteVld = 1'b0;
    endtask

    task automatic sendWord(input logic [31:0] w);
        sendByte(w[31:24]);
        sendByte(w[23:16]);
        sendByte(w[15:8]);
        sendByte(w[7:0]);
    endtask

    task automatic doReset();
        byteVld = 1'b0;
        rst     = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        clearLog();
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    logic [31:0] bubbleWords [5];

    initial begin
        bubbleWords[0] = 32'h0123_4567;
        bubbleWords[1] = 32'h89AB_CDEF;
        bubbleWords[2] = 32'hFFFF_FFFF;
        bubbleWords[3] = 32'h0000_0000;
        bubbleWords[4] = 32'h5A5A_A5A4;

        // ---- reset values ----
        @(posedge clk);
        #1;
        checkEq("rst.ready",   byteRdy,  1'b1);
        checkEq("rst.wrEn",    wrEn,     1'b0);
        checkEq("rst.wrAddr",  wrAddr,   32'h0);
        checkEq("rst.wrData",  wrData,   32'h0);
        checkEq("rst.cpuRst",  cpuRst,   1'b1);
        checkEq("rst.done",    loadDone, 1'b0);
        checkEq("rst.err",     err,      1'b0);
        rst = 1'b0;
        clearLog();

        // ---- N=1, 20 08 00 05, CHECK 2D ----
        sendByte(8'h01);
        sendWord(32'h2008_0005);
        checkEq("t1.wrEnPulse", wrEn,   1'b1);
        checkEq("t1.cpuRstHeld", cpuRst, 1'b1);
        sendByte(8'h2D);
        checkEq("t1.wrEnLow",  wrEn,     1'b0);
        checkEq("t1.wrHold",   wrData,   32'h2008_0005);
        checkEq("t1.cpuRst",   cpuRst,   1'b0);
        checkEq("t1.done",     loadDone, 1'b1);
        checkEq("t1.ready",    byteRdy,  1'b0);
        checkEq("t1.nWrites",  logAddr.size(), 1);
        if (logAddr.size() == 1) begin
            checkEq("t1.addr", logAddr[0], 32'h0);
            checkEq("t1.data", logData[0], 32'h2008_0005);
        end

        // ---- N=3 back-to-back, base 0x100 on dut1, CHECK 0x40 ----
        doReset();
        sendByte(8'h03);
        sendWord(32'h1122_3344);
        sendWord(32'hAABB_CCDD);
        sendWord(32'h0102_0304);
        sendByte(8'h40);
        checkEq("t2.nWrites",  logAddr.size(), 3);
        checkEq("t2.nWrites1", logAddr1.size(), 3);
        if (logAddr.size() == 3 && logAddr1.size() == 3) begin
            checkEq("t2.addr1_0", logAddr1[0], 32'h100);
            checkEq("t2.addr1_1", logAddr1[1], 32'h104);
            checkEq("t2.addr1_2", logAddr1[2], 32'h108);
            checkEq("t2.addr0_2", logAddr[2],  32'h8);
            checkEq("t2.data0",   logData[0],  32'h1122_3344);
            checkEq("t2.data1",   logData[1],  32'hAABB_CCDD);
            checkEq("t2.data2",   logData[2],  32'h0102_0304);
            checkEq("t2.space01", logCyc[1] - logCyc[0], 4);
            checkEq("t2.space12", logCyc[2] - logCyc[1], 4);
        end
        checkEq("t2.done1", loadDone1, 1'b1);
        checkEq("t2.done0", loadDone,  1'b1);

        // ---- N=2, bad CHECK (0x3D instead of 0x3C) ----
        doReset();
        sendByte(8'h02);
        sendWord(32'h3C01_1000);
        sendWord(32'h3421_0004);
        sendByte(8'h3D);
        checkEq("t3.err",    err,     1'b1);
        checkEq("t3.cpuRst", cpuRst,  1'b1);
        checkEq("t3.ready",  byteRdy, 1'b0);
        checkEq("t3.done",   loadDone, 1'b0);
        byteDat = 8'hFF;
        byteVld = 1'b1;
        idle(6);
        byteVld = 1'b0;
        checkEq("t3.nWrites",  logAddr.size(), 2);
        checkEq("t3.errStick", err, 1'b1);
        if (logData.size() == 2) checkEq("t3.data1", logData[1], 32'h3421_0004);

        // ---- N=0, CHECK 00 -> DONE; CHECK 01 -> ERROR ----
        doReset();
        sendByte(8'h00);
        checkEq("t4.notYetDone", loadDone, 1'b0);
        sendByte(8'h00);
        checkEq("t4.done",    loadDone, 1'b1);
        checkEq("t4.cpuRst",  cpuRst,   1'b0);
        checkEq("t4.nWrites", logAddr.size(), 0);
        doReset();
        sendByte(8'h00);
        sendByte(8'h01);
        checkEq("t4.err",     err,      1'b1);
        checkEq("t4.errDone", loadDone, 1'b0);

        // ---- reset mid-load, then fresh N=1 frame ----
        doReset();
        sendByte(8'h04);
        sendWord(32'h1111_2222);
        sendByte(8'h33);
        sendByte(8'h44);
        byteDat = 8'h55;
        byteVld = 1'b1;
        rst     = 1'b1;
        @(posedge clk);
        #1;
        checkEq("t5.rst.ready",  byteRdy,  1'b1);
        checkEq("t5.rst.wrEn",   wrEn,     1'b0);
        checkEq("t5.rst.wrAddr", wrAddr,   32'h0);
        checkEq("t5.rst.wrData", wrData,   32'h0);
        checkEq("t5.rst.cpuRst", cpuRst,   1'b1);
        checkEq("t5.rst.done",   loadDone, 1'b0);
        checkEq("t5.rst.err",    err,      1'b0);
        byteVld = 1'b0;
        rst     = 1'b0;
        clearLog();
        sendByte(8'h01);
        sendWord(32'hDEAD_BEEF);
        sendByte(8'h22);
        checkEq("t5.nWrites", logAddr.size(), 1);
        if (logAddr.size() == 1) begin
            checkEq("t5.addr", logAddr[0], 32'h0);
            checkEq("t5.data", logData[0], 32'hDEAD_BEEF);
        end
        checkEq("t5.done", loadDone, 1'b1);

        // ---- N=5 with random bubbles, CHECK 0x01 ----
        doReset();
        idle($urandom_range(0, 3));
        sendByte(8'h05);
        for (int w = 0; w < 5; w++) begin
            for (int b = 3; b >= 0; b--) begin
                idle($urandom_range(0, 3));
                sendByte(bubbleWords[w][8*b +: 8]);
            end
        end
        idle($urandom_range(0, 3));
        checkEq("t6.notYetDone", loadDone, 1'b0);
        sendByte(8'h01);
        checkEq("t6.nWrites", logAddr.size(), 5);
        if (logAddr.size() == 5) begin
            for (int w = 0; w < 5; w++) begin
                checkEq($sformatf("t6.addr%0d", w), logAddr[w], 32'(4 * w));
                checkEq($sformatf("t6.data%0d", w), logData[w], bubbleWords[w]);
            end
        end
        checkEq("t6.done", loadDone, 1'b1);
        checkEq("t6.err",  err,      1'b0);

        $display("test done: total=%0d bad=%0d", totalCnt, badCnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
